// File: rtl/popcnt_stream_acc_pkg.sv
// Shared mode encodings and elaboration helpers for the streaming popcount accumulator.
package popcnt_pkg;

  localparam logic [1:0] MODE_A   = 2'b00;
  localparam logic [1:0] MODE_AND = 2'b01;
  localparam logic [1:0] MODE_OR  = 2'b10;
  localparam logic [1:0] MODE_XOR = 2'b11;

  // Widest granule granule_pop can count; callers zero-extend narrower slices.
  localparam int GRANULE_MAX = 32;

  function automatic int clog3(input int n);
    int depth;
    int span;
    depth = 0;
    span  = 1;
    while (span < n) begin
      span  = span * 3;
      depth = depth + 1;
    end
    return depth;
  endfunction

  function automatic int sum_width(input int bus_width, input int max_beats);
    return $clog2(bus_width * max_beats + 1);
  endfunction

  function automatic logic [5:0] granule_pop(input logic [GRANULE_MAX-1:0] g);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < GRANULE_MAX; i++) begin
      c = c + {5'b0, g[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/popcnt_stream_acc_if.sv
// Beat stream into the accumulator and packet count out of it.
interface popcnt_stream_acc_if
  import popcnt_pkg::*;
#(
  parameter int BUS_WIDTH = 64,
  parameter int MAX_BEATS = 16,
  parameter int SUM_WIDTH = sum_width(BUS_WIDTH, MAX_BEATS)
);

  logic                 i_Valid;
  logic                 i_Last;
  logic [1:0]           i_Mode;
  logic [BUS_WIDTH-1:0] i_VecA;
  logic [BUS_WIDTH-1:0] i_VecB;
  logic                 o_Valid;
  logic [SUM_WIDTH-1:0] o_Sum;
  logic                 o_Overflow;

  modport master (
    output i_Valid, i_Last, i_Mode, i_VecA, i_VecB,
    input  o_Valid, o_Sum, o_Overflow
  );

  modport slave (
    input  i_Valid, i_Last, i_Mode, i_VecA, i_VecB,
    output o_Valid, o_Sum, o_Overflow
  );

endinterface

// File: rtl/popcnt_stream_acc_tree.sv
// Granule LUT counts followed by a pipelined 3:1 adder tree; valid/last ride alongside.
module popcnt_tree
  import popcnt_pkg::*;
#(
  parameter int BUS_WIDTH     = 64,
  parameter int GRANULE_WIDTH = 6,
  localparam int CNT_WIDTH    = $clog2(BUS_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 vec_valid,
  input  logic                 vec_last,
  input  logic [BUS_WIDTH-1:0] vec,
  output logic                 cnt_valid,
  output logic                 cnt_last,
  output logic [CNT_WIDTH-1:0] cnt
);

  localparam int NUM_GRANULES = (BUS_WIDTH + GRANULE_WIDTH - 1) / GRANULE_WIDTH;
  localparam int DEPTH        = clog3(NUM_GRANULES);
  localparam int LEAVES       = 3 ** DEPTH;
  localparam int PAD_WIDTH    = LEAVES * GRANULE_WIDTH;
  localparam int NODES        = (3 * LEAVES - 1) / 2;

  // All tree levels live in one flat array; level l starts at lvl_off(l).
  function automatic int lvl_off(input int l, input int leaves);
    int off;
    off = 0;
    for (int k = 0; k < l; k++) begin
      off = off + leaves / (3 ** k);
    end
    return off;
  endfunction

  logic [PAD_WIDTH-1:0] vec_pad;
  logic [CNT_WIDTH-1:0] node_reg [NODES];
  logic [DEPTH:0]       valid_reg;
  logic [DEPTH:0]       last_reg;

  // Granules past the bus are all-zero and count as zero.
  assign vec_pad = PAD_WIDTH'(vec);

  for (genvar gi = 0; gi < LEAVES; gi++) begin : g_granule
    always_ff @(posedge clk) begin
      node_reg[gi] <= CNT_WIDTH'(granule_pop(GRANULE_MAX'(vec_pad[gi*GRANULE_WIDTH +: GRANULE_WIDTH])));
    end
  end

  for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_level
    for (genvar gj = 0; gj < LEAVES / (3 ** gi); gj++) begin : g_node
      localparam int SRC = lvl_off(gi - 1, LEAVES) + 3 * gj;
      localparam int DST = lvl_off(gi, LEAVES) + gj;
      always_ff @(posedge clk) begin
        node_reg[DST] <= node_reg[SRC] + node_reg[SRC+1] + node_reg[SRC+2];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_reg <= '0;
      last_reg  <= '0;
    end else begin
      valid_reg[0] <= vec_valid;
      last_reg[0]  <= vec_last;
      for (int k = 1; k <= DEPTH; k++) begin
        valid_reg[k] <= valid_reg[k-1];
        last_reg[k]  <= last_reg[k-1];
      end
    end
  end

  assign cnt_valid = valid_reg[DEPTH];
  assign cnt_last  = last_reg[DEPTH];
  assign cnt       = node_reg[NODES-1];

endmodule

// File: rtl/popcnt_stream_acc.sv
// Streaming popcount accumulator: mode-combine stage, popcount tree, per-packet accumulate
// stage with beat counting and overflow flag.
module popcnt_stream_acc
  import popcnt_pkg::*;
#(
  parameter int BUS_WIDTH     = 64,
  parameter int GRANULE_WIDTH = 6,
  parameter int MAX_BEATS     = 16
) (
  input logic                clk,
  input logic                rstn,
  popcnt_stream_acc_if.slave bus
);

  localparam int SUM_WIDTH  = sum_width(BUS_WIDTH, MAX_BEATS);
  localparam int CNT_WIDTH  = $clog2(BUS_WIDTH + 1);
  localparam int BEAT_WIDTH = $clog2(MAX_BEATS + 2);
  localparam logic [BEAT_WIDTH-1:0] BEAT_MAX = BEAT_WIDTH'(MAX_BEATS);
  localparam logic [BEAT_WIDTH-1:0] BEAT_SAT = BEAT_WIDTH'(MAX_BEATS + 1);

  logic [BUS_WIDTH-1:0]  comb_next;
  logic [BUS_WIDTH-1:0]  comb_reg;
  logic                  s0_valid_reg;
  logic                  s0_last_reg;
  logic                  cnt_valid;
  logic                  cnt_last;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [SUM_WIDTH-1:0]  acc_reg;
  logic [SUM_WIDTH-1:0]  acc_next;
  logic [BEAT_WIDTH-1:0] beats_reg;
  logic [BEAT_WIDTH-1:0] beats_next;
  logic                  first_reg;
  logic                  valid_reg;
  logic [SUM_WIDTH-1:0]  sum_reg;
  logic                  ovf_reg;

  always_comb begin
    comb_next = bus.i_VecA;
    case (bus.i_Mode)
      MODE_AND: comb_next = bus.i_VecA & bus.i_VecB;
      MODE_OR:  comb_next = bus.i_VecA | bus.i_VecB;
      MODE_XOR: comb_next = bus.i_VecA ^ bus.i_VecB;
      default:  comb_next = bus.i_VecA;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s0_valid_reg <= 1'b0;
      s0_last_reg  <= 1'b0;
    end else begin
      s0_valid_reg <= bus.i_Valid;
      s0_last_reg  <= bus.i_Valid & bus.i_Last;
    end
  end

  always_ff @(posedge clk) begin
    comb_reg <= comb_next;
  end

  popcnt_tree #(
    .BUS_WIDTH     (BUS_WIDTH),
    .GRANULE_WIDTH (GRANULE_WIDTH)
  ) u_tree (
    .clk       (clk),
    .rstn      (rstn),
    .vec_valid (s0_valid_reg),
    .vec_last  (s0_last_reg),
    .vec       (comb_reg),
    .cnt_valid (cnt_valid),
    .cnt_last  (cnt_last),
    .cnt       (cnt)
  );

  always_comb begin
    acc_next   = (first_reg ? '0 : acc_reg) + SUM_WIDTH'(cnt);
    beats_next = (beats_reg == BEAT_SAT) ? beats_reg : beats_reg + BEAT_WIDTH'(1);
  end

  // sum_reg/ovf_reg only move on a packet's last beat so they hold between pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_reg   <= '0;
      beats_reg <= '0;
      first_reg <= 1'b1;
      valid_reg <= 1'b0;
      sum_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (cnt_valid) begin
        if (cnt_last) begin
          acc_reg   <= '0;
          beats_reg <= '0;
          first_reg <= 1'b1;
          valid_reg <= 1'b1;
          sum_reg   <= acc_next;
          ovf_reg   <= (beats_next > BEAT_MAX);
        end else begin
          acc_reg   <= acc_next;
          beats_reg <= beats_next;
          first_reg <= 1'b0;
        end
      end
    end
  end

  assign bus.o_Valid    = valid_reg;
  assign bus.o_Sum      = sum_reg;
  assign bus.o_Overflow = ovf_reg;

endmodule

// File: tb/tb_popcnt_stream_acc.sv
// Directed bench for popcnt_stream_acc: hand-computed packet sums, overflow, latency, reset.
module tb_popcnt_stream_acc;
  import popcnt_pkg::*;

  localparam int BW = 64;
  localparam int SW = 11;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int   cyc      = 0;
  int   n_vec    = 0;
  int   n_miss   = 0;
  int   n_pulses = 0;

  logic [SW-1:0] q_sum[$];
  logic          q_ovf[$];
  int            q_cyc[$];

  popcnt_stream_acc_if #(.BUS_WIDTH(BW), .MAX_BEATS(16)) bus ();

  popcnt_stream_acc #(
    .BUS_WIDTH     (BW),
    .GRANULE_WIDTH (6),
    .MAX_BEATS     (16)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_Valid) begin
      q_sum.push_back(bus.o_Sum);
      q_ovf.push_back(bus.o_Overflow);
      q_cyc.push_back(cyc);
      n_pulses++;
      $display("pulse: cycle %0d o_Sum=%0d o_Overflow=%0d", cyc, bus.o_Sum, bus.o_Overflow);
    end
  end

  task automatic chk(input string tag, input longint got, input longint want);
    n_vec++;
    assert (got === want) else begin
      n_miss++;
      $error("FAIL %s: observed %0d, expected %0d", tag, got, want);
    end
  endtask

  // Drives one beat on the next falling edge; samp is the cycle number of the sampling edge.
  task automatic send(input logic last, input logic [1:0] mode, input logic [BW-1:0] a,
                      input logic [BW-1:0] b, output int samp);
    @(negedge clk);
    bus.i_Valid = 1'b1;
    bus.i_Last  = last;
    bus.i_Mode  = mode;
    bus.i_VecA  = a;
    bus.i_VecB  = b;
    samp = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.i_Valid = 1'b0;
      bus.i_Last  = 1'b0;
    end
  endtask

  task automatic expect_pkt(input string tag, input longint esum, input longint eovf, input int esamp);
    int waited;
    waited = 0;
    while (q_sum.size() == 0 && waited < 40) begin
      @(negedge clk);
      #1;
      waited++;
    end
    n_vec++;
    assert (q_sum.size() != 0) else begin
      n_miss++;
      $error("FAIL %s_timeout: observed no pulse in %0d cycles, expected sum %0d", tag, waited, esum);
    end
    if (q_sum.size() != 0) begin
      chk({tag, "_sum"}, q_sum.pop_front(), esum);
      chk({tag, "_ovf"}, q_ovf.pop_front(), eovf);
      chk({tag, "_latency"}, q_cyc.pop_front() - esamp, 5);
    end
  endtask

  initial begin
    int s_a, s_b, s_c, s_d, unused_samp;
    bus.i_Valid = 1'b0;
    bus.i_Last  = 1'b0;
    bus.i_Mode  = MODE_A;
    bus.i_VecA  = '0;
    bus.i_VecB  = '0;

    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_o_Valid", bus.o_Valid, 0);
    chk("rst_o_Sum", bus.o_Sum, 0);
    chk("rst_o_Overflow", bus.o_Overflow, 0);
    @(negedge clk);
    rstn = 1'b1;

    send(1'b1, MODE_A, {BW{1'b1}}, '0, s_a);
    idle(1);
    expect_pkt("ones_single", 64, 0, s_a);
    @(negedge clk);
    #1;
    chk("pulse_width", bus.o_Valid, 0);
    chk("sum_hold", bus.o_Sum, 64);

    send(1'b1, MODE_AND, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, s_a);
    send(1'b1, MODE_OR,  64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, s_b);
    send(1'b1, MODE_XOR, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, s_c);
    send(1'b1, MODE_A,   64'h0, {BW{1'b1}}, s_d);
    idle(1);
    expect_pkt("mode_and", 16, 0, s_a);
    expect_pkt("mode_or", 48, 0, s_b);
    expect_pkt("mode_xor", 32, 0, s_c);
    expect_pkt("mode_a_zero", 0, 0, s_d);

    send(1'b0, MODE_A,   64'h1111_1111_1111_1111, '0, unused_samp);
    send(1'b0, MODE_AND, 64'h1111_1111_1111_1111, {BW{1'b1}}, unused_samp);
    idle(2);
    send(1'b1, MODE_A, 64'h1111_1111_1111_1111, '0, s_a);
    send(1'b1, MODE_A, 64'h0, '0, s_b);
    idle(1);
    expect_pkt("three_beat_gaps", 48, 0, s_a);
    expect_pkt("zero_after", 0, 0, s_b);

    for (int i = 0; i < 32; i++) begin
      send(i == 31, MODE_A, {BW{1'b1}}, '0, s_a);
    end
    send(1'b1, MODE_A, 64'h3, '0, s_b);
    idle(1);
    expect_pkt("beats32_wrap", 0, 1, s_a);
    expect_pkt("after_ovf", 2, 0, s_b);

    for (int i = 0; i < 16; i++) begin
      send(i == 15, MODE_A, {BW{1'b1}}, '0, s_a);
    end
    idle(1);
    expect_pkt("beats16_edge", 1024, 0, s_a);

    send(1'b0, MODE_A, {BW{1'b1}}, '0, unused_samp);
    send(1'b0, MODE_A, {BW{1'b1}}, '0, unused_samp);
    @(negedge clk);
    bus.i_Valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("midrst_o_Valid", bus.o_Valid, 0);
    chk("midrst_o_Sum", bus.o_Sum, 0);
    chk("midrst_o_Overflow", bus.o_Overflow, 0);
    @(negedge clk);
    rstn = 1'b1;
    send(1'b1, MODE_A, 64'h0F, '0, s_a);
    idle(1);
    expect_pkt("after_reset", 4, 0, s_a);

    idle(12);
    chk("no_stale_pulse", q_sum.size(), 0);
    chk("pulse_count", n_pulses, 11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/popcnt_stream_acc.md
# popcnt_stream_acc

Streaming, fully pipelined population counter for the Tanimoto datapath. It counts set bits of a bitwise combination of two input vectors (A, A&B, A|B or A^B). Fingerprints wider than the bus arrive as multi-beat packets, and the block accumulates one count per packet. It accepts one beat per clock and feeds the similarity-score stage with |A|, |B| and |A∩B| counts.

## Interface
- BUS_WIDTH, 64: bits per beat on i_VecA/i_VecB.
- GRANULE_WIDTH, 6: bits counted by one LUT granule in the first count stage.
- MAX_BEATS, 16: nominal maximum beats per packet. Sizes the sum and beat counter.
- Derived SUM_WIDTH = $clog2(BUS_WIDTH*MAX_BEATS+1), 11 at defaults.
- Derived TREE_DEPTH = ceil(log3(ceil(BUS_WIDTH/GRANULE_WIDTH))), 3 at defaults.
- Clock is clk; reset is rstn. One clock; reset is asynchronous and active-low.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- i_Valid  in  1  beat present this cycle.
- i_Last  in  1  final beat of packet; qualified by i_Valid.
- i_Mode  in  2  per-beat operand select: 00=A, 01=A&B, 10=A|B, 11=A^B.
- i_VecA  in  BUS_WIDTH  operand A.
- i_VecB  in  BUS_WIDTH  operand B. Ignored in mode 00.
- o_Valid  out  1  one-cycle pulse; packet count is valid.
- o_Sum  out  SUM_WIDTH  packet popcount.
- o_Overflow  out  1  packet exceeded MAX_BEATS beats; qualified by o_Valid.

## Operation
- No backpressure. Every cycle with i_Valid=1 is accepted.
- i_Valid=0 cycles may appear between beats of one packet. The accumulator holds across them.
- Stage 0 registers the mode-combined vector plus valid/last.
- Stage 1 registers per-granule counts. The final granule is zero-padded when BUS_WIDTH % GRANULE_WIDTH ≠ 0.
- Stages 2..TREE_DEPTH+1 form a 3:1 adder tree, one level per stage. Valid and last travel alongside the data.
- The accumulate stage applies on a valid beat:
  - acc_next = (first ? 0 : acc) + beat_count, modulo 2^SUM_WIDTH.
  - The beat counter increments, saturating at MAX_BEATS+1.
  - first is set by reset and by any accumulated last beat. It is cleared by any accumulated non-last beat.
- On an accumulated last beat:
  - o_Sum = acc_next, o_Valid = 1 for exactly one cycle.
  - o_Overflow = (beat count > MAX_BEATS).
  - The accumulator and beat counter clear.
- A one-beat packet (first beat has i_Last=1) is legal.
- i_Mode is applied per beat. Changing it mid-packet is legal, and each beat uses its own mode.
- o_Sum and o_Overflow hold their last values while o_Valid=0.

## Timing
- LATENCY = TREE_DEPTH+2 rising edges, counted from the edge that samples the last beat to the edge that raises o_Valid. This is 5 at defaults.
- Throughput is one beat per clock. Back-to-back packets give o_Valid pulses spaced by their beat counts, with no bubbles.
- Reset, asynchronous at any time:
  - o_Valid=0, o_Sum=0, o_Overflow=0.
  - All pipeline valid bits clear, accumulator=0, beat counter=0, first=1.
- Reset mid-packet: in-flight beats and the partial sum are discarded, with no output pulse. The first beat after release starts a new packet.
- Datapath registers other than valid/last/accumulator need no reset.
- Overflow: accumulation continues past MAX_BEATS and wraps modulo 2^SUM_WIDTH. o_Overflow flags the packet.

## Structure
- Package popcnt_pkg holds:
  - Mode constants MODE_A/MODE_AND/MODE_OR/MODE_XOR.
  - Function clog3 for TREE_DEPTH.
  - Function granule_pop, the GRANULE_WIDTH-bit LUT count.
  - Width helper for SUM_WIDTH.
- Sub-module popcnt_tree: the granule stage plus the pipelined 3:1 adder tree, with a valid/last sideband.
- The top level holds the mode stage, accumulator, beat counter and output registers.

## Test plan
- Single beat, mode 00, A=64'hFFFF_FFFF_FFFF_FFFF, last=1 → o_Sum=64, o_Overflow=0, o_Valid one cycle, 5 edges after sampling.
- Single-beat packets with A=64'hF0F0_F0F0_F0F0_F0F0 and B=64'hFF00_FF00_FF00_FF00:
  - mode 01 → 16.
  - mode 10 → 48.
  - mode 11 → 32.
  - mode 00 with A=0, B=all-ones → 0.
- 3-beat packet, A=64'h1111_1111_1111_1111 each beat, 2 idle cycles before beat 3 → o_Sum=48. It is immediately followed by a one-beat all-zero packet → o_Sum=0 on the next o_Valid, with no extra pulses.
- 32 back-to-back all-ones beats, mode 00, last on beat 32 → o_Sum=0 (2048 mod 2048), o_Overflow=1. A following 1-beat packet of 64'h3 → o_Sum=2, o_Overflow=0.
- Two beats accepted, rstn low for one cycle mid-packet, then one beat A=64'h0F with last → outputs 0 during reset, no stale pulse, then o_Sum=4.
